// File: rtl/led_pkg.sv
// Shared constants for the LED fade/PWM stage: channel count, default widths, full-scale helper.
// Latency: none (package only).
// Backpressure: none (package only).
// Optional feature macro used by the design: LED_FADE_GAMMA_EN.
package led_pkg;
    localparam int LED_N         = 8;
    localparam int PWM_BITS_DEF  = 8;
    localparam int FADE_STEP_DEF = 16;

    // Full-scale value of a PWM_BITS-wide level/counter.
    function automatic int max_of(input int bits);
        return (1 << bits) - 1;
    endfunction

    localparam int MAX_DEF = max_of(PWM_BITS_DEF);
endpackage

// File: rtl/pwm_channel.sv
// One LED channel: saturating fade level, optional gamma stage (LED_FADE_GAMMA_EN), PWM compare flop.
// Latency: led follows a level update 1 clk later (2 clk with LED_FADE_GAMMA_EN).
// Backpressure: none; step is a strobe and the channel updates unconditionally.
module pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS  = PWM_BITS_DEF,
    parameter int FADE_STEP = FADE_STEP_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step,
    input  logic                tgt,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);
    localparam logic [PWM_BITS:0]   MAX_W  = {1'b0, {PWM_BITS{1'b1}}};
    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(FADE_STEP);
    localparam logic [PWM_BITS-1:0] MAX_N  = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS:0]   level_ext, up_sum;
    logic [PWM_BITS-1:0] duty;
    logic                led_q, led_d;

    // Next level: ramp toward the target bit in one extra bit of headroom, clamped at both ends.
    always_comb begin
        level_ext = {1'b0, level_q};
        up_sum    = level_ext + STEP_W;
        level_d   = level_q;
        if (step) begin
            if (tgt) begin
                level_d = (up_sum > MAX_W) ? MAX_N : up_sum[PWM_BITS-1:0];
            end else begin
                level_d = (level_ext < STEP_W) ? '0 : level_q - STEP_W[PWM_BITS-1:0];
            end
        end
    end

    // Level register; reset aborts any fade in progress.
    always_ff @(posedge clk) begin
        if (reset) level_q <= '0;
        else       level_q <= level_d;
    end

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] prod;
    logic [PWM_BITS-1:0]   duty_q;

    assign prod = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};

    // Squared-level duty register; full-scale level stays fully on instead of 254/256.
    always_ff @(posedge clk) begin
        if (reset)                duty_q <= '0;
        else if (level_q == MAX_N) duty_q <= MAX_N;
        else                      duty_q <= prod[2*PWM_BITS-1:PWM_BITS];
    end

    assign duty = duty_q;
`else
    assign duty = level_q;
`endif

    // Compare: full-scale duty is forced on so the wrap cycle does not glitch low.
    always_comb begin
        led_d = (duty == MAX_N) ? 1'b1 : (pwm_cnt < duty);
    end

    // Registered LED drive.
    always_ff @(posedge clk) begin
        if (reset) led_q <= 1'b0;
        else       led_q <= led_d;
    end

    assign led = led_q;
endmodule

// File: rtl/led_fade_pwm.sv
// LED fade stage: per-channel ramped brightness driven as PWM from a shared free-running counter.
// Latency: led reflects a level update 1 clk later (2 clk with LED_FADE_GAMMA_EN defined).
// Backpressure: none; step strobes are consumed on the cycle they arrive.
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int N         = LED_N,
    parameter int PWM_BITS  = PWM_BITS_DEF,
    parameter int FADE_STEP = FADE_STEP_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    input  logic [N-1:0] q_in,
    output logic [N-1:0] led
);
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

    assign pwm_cnt_d = pwm_cnt_q + 1'b1;

    // Free-running PWM counter, wraps naturally at full scale; not gated by step.
    always_ff @(posedge clk) begin
        if (reset) pwm_cnt_q <= '0;
        else       pwm_cnt_q <= pwm_cnt_d;
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        pwm_channel #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .step    (step),
            .tgt     (q_in[i]),
            .pwm_cnt (pwm_cnt_q),
            .led     (led[i])
        );
    end
endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: cycle model pushes expected led per edge, sampled and popped on negedge.
// Latency: model tracks 1 clk (2 clk with LED_FADE_GAMMA_EN) from level update to led.
// Backpressure: none.
module tb_led_fade_pwm;
    localparam int N    = 8;
    localparam int W    = 8;
    localparam int STEP = 16;
    localparam int MAXV = 255;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         step = 1'b0;
    logic [N-1:0] q_in = 8'hFF;
    logic [N-1:0] led;

    int checks = 0;
    int errors = 0;

    led_fade_pwm dut (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .q_in  (q_in),
        .led   (led)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    int          m_level [N];
    int          m_duty  [N];
    int          m_cnt = 0;
    logic [N-1:0] exp_q[$];
    bit          started = 1'b0;

    function automatic int duty_of(input int lv);
`ifdef LED_FADE_GAMMA_EN
        if (lv == MAXV) return MAXV;
        return (lv * lv) >> W;
`else
        return lv;
`endif
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) begin
            int d;
`ifdef LED_FADE_GAMMA_EN
            d = m_duty[i];
`else
            d = m_level[i];
`endif
            e[i] = reset ? 1'b0 : ((d == MAXV) ? 1'b1 : (m_cnt < d));
        end
        for (int i = 0; i < N; i++) begin
            m_duty[i] = reset ? 0 : duty_of(m_level[i]);
            if (reset) m_level[i] = 0;
            else if (step) begin
                if (q_in[i]) m_level[i] = (m_level[i] + STEP > MAXV) ? MAXV : m_level[i] + STEP;
                else         m_level[i] = (m_level[i] < STEP) ? 0 : m_level[i] - STEP;
            end
        end
        m_cnt = reset ? 0 : (m_cnt + 1) % (MAXV + 1);
        exp_q.push_back(e);
        started = 1'b1;
    end

    // Scoreboard compare, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            if (exp_q.size() == 0) check_eq("sb_empty", 0, 1);
            else check_eq("led", int'(led), int'(exp_q.pop_front()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int n);
        for (int k = 0; k < n; k++) begin
            step = 1'b1; cyc();
            step = 1'b0; cyc();
        end
    endtask

    // Observe n consecutive cycles: count led[0] high and count of cycles with led == pat.
    task automatic window(input int n, input logic [N-1:0] pat, output int hi0, output int eqc);
        hi0 = 0; eqc = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (led[0]) hi0++;
            if (led == pat) eqc++;
        end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int hi0, eqc;
        // Reset held 3 clk with target high and step pulsing.
        for (int k = 0; k < 3; k++) begin
            step = (k != 1); cyc();
        end
        step = 1'b0;
        @(negedge clk);
        check_eq("reset_led", int'(led), 0);
        reset = 1'b0; cyc();
        window(4, 8'h00, hi0, eqc);
        check_eq("post_reset_off", eqc, 4);

        // Ramp all channels up to full scale with one extra step of margin for clamping.
        q_in = 8'hFF;
        pulse(17);
        window(300, 8'hFF, hi0, eqc);
        check_eq("full_on", eqc, 300);

        // Ramp down with an extra step: must clamp at zero, not wrap.
        q_in = 8'h00;
        pulse(17);
        window(300, 8'h00, hi0, eqc);
        check_eq("full_off", eqc, 300);

        // Half level on channel 0.
        q_in = 8'h01;
        pulse(8);
        q_in = 8'h00;
        window(256, 8'h00, hi0, eqc);
`ifdef LED_FADE_GAMMA_EN
        check_eq("half_duty", hi0, 64);
`else
        check_eq("half_duty", hi0, 128);
`endif
        check_eq("half_others_off", eqc, 256 - hi0);

        // q_in changes without step must not move levels.
        q_in = 8'hFF;
        window(256, 8'h00, hi0, eqc);
`ifdef LED_FADE_GAMMA_EN
        check_eq("hold_duty", hi0, 64);
`else
        check_eq("hold_duty", hi0, 128);
`endif

        // Partial fade then 1-clk reset: everything back to zero.
        q_in = 8'h0F;
        pulse(4);
        reset = 1'b1; cyc();
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_reset_led", int'(led), 0);
        cyc();
        window(300, 8'h00, hi0, eqc);
        check_eq("mid_reset_off", eqc, 300);

        // Fade restarts from zero: one step gives 16/256 duty without gamma.
        q_in = 8'h01;
        pulse(1);
        q_in = 8'h00;
        window(256, 8'h00, hi0, eqc);
`ifdef LED_FADE_GAMMA_EN
        check_eq("restart_duty", hi0, 1);
`else
        check_eq("restart_duty", hi0, 16);
`endif

        // Random step/target traffic checked against the model every cycle.
        for (int k = 0; k < 2000; k++) begin
            step = ($urandom_range(0, 3) == 0);
            q_in = N'($urandom);
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            else reset = 1'b0;
            cyc();
        end
        step = 1'b0; reset = 1'b0;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
